// File: rtl/rs_enc_lfsr.sv
// Systematic Reed-Solomon t=2 encoder over GF(2^8) (poly 0x11D). Message symbols pass
// through with one cycle of latency, followed by 4 parity symbols from the generator LFSR.
//
// state | meaning
// S_MSG | passing message symbols through, LFSR accumulating the remainder
// S_PAR | draining the 4 parity symbols, p3 first
module rs_enc_lfsr #(
   parameter int MAX_K = 251
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic       enc_in_valid,
   input  logic [7:0] enc_in_data,
   input  logic       enc_in_last,
   output logic       enc_in_ready,
   output logic       enc_out_valid,
   output logic [7:0] enc_out_data,
   output logic       enc_out_last,
   input  logic       enc_out_ready,
   output logic       enc_err
);

   typedef enum logic {S_MSG, S_PAR} state_t;

   localparam logic [7:0] MAX_K_M1 = 8'(MAX_K - 1);

   // constant-operand GF(2^8) multiply; collapses to an XOR network per coefficient
   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] acc;
      logic [7:0] sh;
      acc = 8'h00;
      sh  = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) acc = acc ^ sh;
         sh = {sh[6:0], 1'b0} ^ (sh[7] ? 8'h1D : 8'h00);
      end
      return acc;
   endfunction

   state_t     state;
   logic [7:0] p3, p2, p1, p0;
   logic [7:0] msg_cnt;
   logic [1:0] par_idx;

   logic       out_free;
   logic       in_acc;
   logic       msg_end;
   logic [7:0] fb;

   assign out_free     = !enc_out_valid | enc_out_ready;
   assign enc_in_ready = (state == S_MSG) & out_free;
   assign in_acc       = enc_in_valid & enc_in_ready;
   assign msg_end      = enc_in_last | (msg_cnt == MAX_K_M1);
   assign fb           = enc_in_data ^ p3;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state         <= S_MSG;
         p3            <= 8'h00;
         p2            <= 8'h00;
         p1            <= 8'h00;
         p0            <= 8'h00;
         msg_cnt       <= 8'h00;
         par_idx       <= 2'd0;
         enc_out_valid <= 1'b0;
         enc_out_data  <= 8'h00;
         enc_out_last  <= 1'b0;
         enc_err       <= 1'b0;
      end else begin
         enc_err <= 1'b0;
         if (state == S_MSG) begin
            if (in_acc) begin
               p3            <= p2 ^ gf_mul(fb, 8'h0F);
               p2            <= p1 ^ gf_mul(fb, 8'h36);
               p1            <= p0 ^ gf_mul(fb, 8'h78);
               p0            <= gf_mul(fb, 8'h40);
               enc_out_data  <= enc_in_data;
               enc_out_valid <= 1'b1;
               enc_out_last  <= 1'b0;
               if (msg_end) begin
                  state   <= S_PAR;
                  par_idx <= 2'd0;
                  // truncation at MAX_K without an explicit last marker
                  enc_err <= ~enc_in_last;
               end else begin
                  msg_cnt <= msg_cnt + 8'd1;
               end
            end else if (enc_out_ready) begin
               enc_out_valid <= 1'b0;
            end
         end else begin
            if (out_free) begin
               enc_out_data  <= p3;
               enc_out_valid <= 1'b1;
               enc_out_last  <= (par_idx == 2'd3);
               p3            <= p2;
               p2            <= p1;
               p1            <= p0;
               p0            <= 8'h00;
               par_idx       <= par_idx + 2'd1;
               if (par_idx == 2'd3) begin
                  state   <= S_MSG;
                  msg_cnt <= 8'h00;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_rs_enc_lfsr.sv
// Bench for rs_enc_lfsr: two instances (MAX_K=251 and MAX_K=4) checked every cycle
// against a polynomial-division model, plus syndrome checks on every output codeword.
module tb_rs_enc_lfsr;

   logic clk = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;

   logic [1:0]      in_valid, in_last, in_ready, out_valid, out_last, out_ready, err;
   logic [1:0][7:0] in_data, out_data;

   rs_enc_lfsr #(.MAX_K(251)) dut (
      .clk(clk), .rstn(rstn),
      .enc_in_valid(in_valid[0]), .enc_in_data(in_data[0]), .enc_in_last(in_last[0]),
      .enc_in_ready(in_ready[0]),
      .enc_out_valid(out_valid[0]), .enc_out_data(out_data[0]), .enc_out_last(out_last[0]),
      .enc_out_ready(out_ready[0]), .enc_err(err[0])
   );

   rs_enc_lfsr #(.MAX_K(4)) dut_k4 (
      .clk(clk), .rstn(rstn),
      .enc_in_valid(in_valid[1]), .enc_in_data(in_data[1]), .enc_in_last(in_last[1]),
      .enc_in_ready(in_ready[1]),
      .enc_out_valid(out_valid[1]), .enc_out_data(out_data[1]), .enc_out_last(out_last[1]),
      .enc_out_ready(out_ready[1]), .enc_err(err[1])
   );

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;
   int rmode = 0;
   int ph = 0;

   logic [7:0] gexp [256];
   int         glog [256];

   int         maxk [2];
   logic [8:0] expq [2][$];
   logic [7:0] msgbuf [2][$];
   logic [7:0] cw [2][$];
   logic [8:0] log_sym [2][$];
   int         log_cyc [2][$];
   logic       pend_err [2];
   logic       stalled [2];
   logic [8:0] held [2];
   int         err_seen [2];

   task automatic chk(input string name, input int ch, input int got, input int want);
      vectors++;
      if (got != want) begin
         miscompares++;
         $display("FAIL %s ch%0d got=%0h exp=%0h (cycle %0d)", name, ch, got, want, cyc);
      end
   endtask

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      if (a == 8'h00 || b == 8'h00) return 8'h00;
      return gexp[(glog[a] + glog[b]) % 255];
   endfunction

   function automatic logic [7:0] gcoef(input int j);
      case (j)
         1: return 8'h0F;
         2: return 8'h36;
         3: return 8'h78;
         default: return 8'h40;
      endcase
   endfunction

   // remainder of m(x)*x^4 / g(x) by long division; index 0 is the highest degree
   function automatic logic [3:0][7:0] calc_parity(input logic [7:0] m [$]);
      logic [7:0] r [$];
      logic [3:0][7:0] res;
      r = m;
      repeat (4) r.push_back(8'h00);
      for (int i = 0; i < m.size(); i++) begin
         logic [7:0] c;
         c = r[i];
         for (int j = 1; j <= 4; j++) r[i+j] = r[i+j] ^ gmul(c, gcoef(j));
      end
      for (int j = 0; j < 4; j++) res[j] = r[m.size() + j];
      return res;
   endfunction

   task automatic model_accept(input int ch, input logic [7:0] d, input logic l);
      logic [3:0][7:0] par;
      msgbuf[ch].push_back(d);
      expq[ch].push_back({1'b0, d});
      if (l || msgbuf[ch].size() == maxk[ch]) begin
         par = calc_parity(msgbuf[ch]);
         for (int j = 0; j < 4; j++) expq[ch].push_back({(j == 3), par[j]});
         if (!l) pend_err[ch] = 1'b1;
         msgbuf[ch].delete();
      end
   endtask

   task automatic check_syndromes(input int ch);
      logic [7:0] s;
      for (int i = 0; i < 4; i++) begin
         s = 8'h00;
         foreach (cw[ch][k]) s = gmul(s, gexp[i]) ^ cw[ch][k];
         chk($sformatf("syndrome_S%0d", i), ch, s, 0);
      end
   endtask

   task automatic model_reset();
      for (int ch = 0; ch < 2; ch++) begin
         expq[ch].delete();
         msgbuf[ch].delete();
         cw[ch].delete();
         pend_err[ch] = 1'b0;
         stalled[ch]  = 1'b0;
      end
   endtask

   task automatic clear_logs();
      for (int ch = 0; ch < 2; ch++) begin
         log_sym[ch].delete();
         log_cyc[ch].delete();
         err_seen[ch] = 0;
      end
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   initial forever begin
      @(posedge clk);
      #1;
      ph++;
      case (rmode)
         1:       out_ready = (ph % 3 == 0) ? 2'b11 : 2'b00;
         2:       out_ready = {($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0)};
         default: out_ready = 2'b11;
      endcase
   end

   // compare process: outputs seen here are the ones taken on the coming rising edge
   initial forever begin
      @(negedge clk);
      if (rstn) begin
         for (int ch = 0; ch < 2; ch++) begin
            logic [8:0] e;
            chk("err_pulse", ch, err[ch], pend_err[ch]);
            pend_err[ch] = 1'b0;
            if (err[ch]) err_seen[ch]++;
            if (stalled[ch]) begin
               chk("stall_valid", ch, out_valid[ch], 1);
               chk("stall_hold", ch, {out_last[ch], out_data[ch]}, held[ch]);
            end
            stalled[ch] = out_valid[ch] & ~out_ready[ch];
            held[ch]    = {out_last[ch], out_data[ch]};
            if (out_valid[ch] && out_ready[ch]) begin
               log_sym[ch].push_back({out_last[ch], out_data[ch]});
               log_cyc[ch].push_back(cyc);
               cw[ch].push_back(out_data[ch]);
               if (expq[ch].size() == 0) begin
                  chk("unexpected_output", ch, {out_last[ch], out_data[ch]}, 'h1FF);
               end else begin
                  e = expq[ch].pop_front();
                  chk("out_symbol", ch, {out_last[ch], out_data[ch]}, e);
               end
               if (out_last[ch]) begin
                  check_syndromes(ch);
                  cw[ch].delete();
               end
            end
            if (in_valid[ch] && in_ready[ch]) model_accept(ch, in_data[ch], in_last[ch]);
         end
      end
   end

   task automatic send(input int ch, input logic [7:0] d, input logic l);
      int n;
      n = 0;
      in_valid[ch] = 1'b1;
      in_data[ch]  = d;
      in_last[ch]  = l;
      do begin
         @(negedge clk);
         n++;
      end while (!in_ready[ch] && n < 500);
      if (n >= 500) chk("in_ready_timeout", ch, 0, 1);
      @(posedge clk);
      #1;
      in_valid[ch] = 1'b0;
      in_last[ch]  = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((expq[0].size() != 0 || expq[1].size() != 0) && n < 3000) begin
         @(posedge clk);
         n++;
      end
      chk("drain_timeout", 0, (n >= 3000), 0);
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic check_single_msg(input string tag, input bit consecutive);
      logic [7:0] want [5];
      want = '{8'h01, 8'h0F, 8'h36, 8'h78, 8'h40};
      chk({tag, "_count"}, 0, log_sym[0].size(), 5);
      if (log_sym[0].size() == 5) begin
         for (int i = 0; i < 5; i++) begin
            chk({tag, "_data"}, 0, log_sym[0][i][7:0], want[i]);
            chk({tag, "_last"}, 0, log_sym[0][i][8], (i == 4));
            if (consecutive) chk({tag, "_cycle"}, 0, log_cyc[0][i] - log_cyc[0][0], i);
         end
      end
   endtask

   initial begin
      int x;
      int nz;
      int k;
      logic [7:0] q1 [$];
      logic [3:0][7:0] pp;

      in_valid  = 2'b00;
      in_last   = 2'b00;
      in_data   = '0;
      out_ready = 2'b11;
      maxk[0] = 251;
      maxk[1] = 4;
      model_reset();
      clear_logs();

      x = 1;
      for (int i = 0; i < 255; i++) begin
         gexp[i] = 8'(x);
         glog[x] = i;
         x = x << 1;
         if ((x & 256) != 0) x = x ^ 'h11D;
      end
      gexp[255] = 8'h01;
      glog[0]   = 0;

      chk("pin_gmul_80x02", 0, gmul(8'h80, 8'h02), 8'h1D);
      chk("pin_gmul_inv", 0, gmul(8'h8E, 8'h02), 8'h01);
      q1.push_back(8'h01);
      pp = calc_parity(q1);
      chk("pin_par0", 0, pp[0], 8'h0F);
      chk("pin_par1", 0, pp[1], 8'h36);
      chk("pin_par2", 0, pp[2], 8'h78);
      chk("pin_par3", 0, pp[3], 8'h40);

      #12;
      for (int ch = 0; ch < 2; ch++) begin
         chk("reset_valid", ch, out_valid[ch], 0);
         chk("reset_data", ch, out_data[ch], 0);
         chk("reset_last", ch, out_last[ch], 0);
         chk("reset_err", ch, err[ch], 0);
      end
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      @(posedge clk);
      #1;

      // single-symbol message at full rate
      rmode = 0;
      clear_logs();
      send(0, 8'h01, 1'b1);
      drain();
      check_single_msg("single", 1'b1);

      // all-zero maximal message
      clear_logs();
      for (int i = 0; i < 251; i++) send(0, 8'h00, (i == 250));
      drain();
      chk("zero_count", 0, log_sym[0].size(), 255);
      nz = 0;
      foreach (log_sym[0][i]) if (log_sym[0][i][7:0] != 8'h00) nz++;
      chk("zero_nonzero_syms", 0, nz, 0);
      chk("zero_err_count", 0, err_seen[0], 0);

      // backpressure 1,0,0 repeating
      rmode = 1;
      clear_logs();
      send(0, 8'h01, 1'b1);
      drain();
      check_single_msg("bp", 1'b0);

      // truncation at MAX_K=4
      rmode = 0;
      clear_logs();
      for (int i = 1; i <= 6; i++) send(1, 8'(i), (i == 6));
      drain();
      chk("trunc_count", 1, log_sym[1].size(), 14);
      if (log_sym[1].size() == 14) begin
         for (int i = 0; i < 4; i++) chk("trunc_cw1_msg", 1, log_sym[1][i], i + 1);
         chk("trunc_cw1_last", 1, log_sym[1][7][8], 1);
         chk("trunc_cw2_msg0", 1, log_sym[1][8], 9'h005);
         chk("trunc_cw2_msg1", 1, log_sym[1][9], 9'h006);
         chk("trunc_cw2_last", 1, log_sym[1][13][8], 1);
      end
      chk("trunc_err_count", 1, err_seen[1], 1);

      // randomized messages under random backpressure
      rmode = 2;
      for (int m = 0; m < 30; m++) begin
         k = $urandom_range(1, 40);
         for (int i = 0; i < k; i++) send(0, 8'($urandom_range(0, 255)), (i == k - 1));
      end
      for (int m = 0; m < 15; m++) begin
         k = $urandom_range(1, 9);
         for (int i = 0; i < k; i++) send(1, 8'($urandom_range(0, 255)), (i == k - 1));
      end
      drain();

      // reset in the middle of the parity phase
      rmode = 0;
      clear_logs();
      send(0, 8'h01, 1'b1);
      k = 0;
      while (log_sym[0].size() < 3 && k < 100) begin
         @(posedge clk);
         k++;
      end
      chk("midpar_reach_timeout", 0, (k >= 100), 0);
      #2;
      rstn = 1'b0;
      model_reset();
      #1;
      chk("midpar_rst_valid", 0, out_valid[0], 0);
      chk("midpar_rst_data", 0, out_data[0], 0);
      chk("midpar_rst_last", 0, out_last[0], 0);
      chk("midpar_rst_err", 0, err[0], 0);
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      @(posedge clk);
      #1;
      clear_logs();
      send(0, 8'h01, 1'b1);
      drain();
      check_single_msg("after_rst", 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
